// File: rtl/xadc_pkg.sv
// Shared types and DRP constants for the XADC multi-channel conditioner.
// The FSM walks IDLE -> REQ -> WAIT -> ACC -> (IDLE | SCALE -> OUT -> IDLE).
package xadc_pkg;
    localparam logic [4:0] XADC_AUX_BASE = 5'h10;
    localparam int         DRP_ADDR_W    = 7;
    localparam int         DRP_DATA_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ, ST_WAIT, ST_ACC, ST_SCALE, ST_OUT
    } state_t;

    function automatic logic [15:0] sat16(input logic [31:0] v);
        return (|v[31:16]) ? 16'hFFFF : v[15:0];
    endfunction
endpackage

// File: rtl/xadc_drp_reader.sv
// DRP read engine: one-cycle den pulse, then waits for drdy or gives up.
// hit/expire are combinational so the owning FSM can leave WAIT on the same edge.
module xadc_drp_reader
    import xadc_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4:0]            channel,
    input  logic                  drdy_in,
    input  logic [DRP_DATA_W-1:0] do_in,
    output logic                  den,
    output logic [DRP_ADDR_W-1:0] daddr,
    output logic [DATA_W-1:0]     sample,
    output logic                  hit,
    output logic                  expire
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          waiting;
    logic [TW-1:0] timer;
    wire           unused_ok = &{1'b0, do_in};

    // The timer starts on the den cycle, so expiry lands TIMEOUT cycles after den.
    assign hit    = waiting && !den && drdy_in;
    assign expire = waiting && !den && !drdy_in && (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            den     <= 1'b0;
            daddr   <= '0;
            waiting <= 1'b0;
            timer   <= '0;
            sample  <= '0;
        end else begin
            den <= start;
            if (start) begin
                daddr   <= {2'b00, channel};
                waiting <= 1'b1;
                timer   <= '0;
            end else if (waiting) begin
                if (hit) begin
                    sample  <= do_in[DRP_DATA_W-1 -: DATA_W];
                    waiting <= 1'b0;
                end else if (expire) begin
                    waiting <= 1'b0;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/xadc_multichan_conditioner.sv
// Per-channel block averager and mV scaler behind an XADC DRP reader.
// One tagged result per completed block, held on a valid/ready handshake.
module xadc_multichan_conditioner
    import xadc_pkg::*;
#(
    parameter int         NUM_CH      = 2,
    parameter logic [4:0] FIRST_CH    = 5'h1E,
    parameter int         AVG_LOG2    = 4,
    parameter int         DATA_W      = 12,
    parameter int         SCALE_NUM   = 3300,
    parameter int         SCALE_SHIFT = 12,
    parameter int         DRP_TIMEOUT = 15,
    localparam int        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  eoc_in,
    input  logic [4:0]            channel_in,
    output logic                  den_out,
    output logic [DRP_ADDR_W-1:0] daddr_out,
    input  logic                  drdy_in,
    input  logic [DRP_DATA_W-1:0] do_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH_W-1:0]       out_ch,
    output logic [DATA_W-1:0]     out_raw,
    output logic [DATA_W-1:0]     out_avg,
    output logic [15:0]           out_mv,
    output logic                  overrun,
    output logic                  drp_timeout
);
    localparam int                ACC_W    = DATA_W + AVG_LOG2;
    localparam int                CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int                PROD_W   = DATA_W + 16;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    state_t                        state;
    logic [NUM_CH-1:0][ACC_W-1:0]  acc;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt;
    logic [CH_W-1:0]               ch_q;
    logic [DATA_W-1:0]             raw_q, avg_q, rd_sample;
    logic                          rd_hit, rd_expire, start, ch_ok;
    logic [4:0]                    ch_off;
    logic [ACC_W-1:0]              acc_sum;
    logic [PROD_W-1:0]             prod;

    // Channels below FIRST_CH wrap to large offsets and fail the range check.
    assign ch_off  = channel_in - FIRST_CH;
    assign ch_ok   = int'(ch_off) < NUM_CH;
    assign start   = (state == ST_IDLE) && eoc_in && ch_ok;
    assign acc_sum = acc[ch_q] + ACC_W'(rd_sample);
    assign prod    = PROD_W'(avg_q) * PROD_W'(SCALE_NUM);

    xadc_drp_reader #(.DATA_W(DATA_W), .TIMEOUT(DRP_TIMEOUT)) u_drp (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .channel (channel_in),
        .drdy_in (drdy_in),
        .do_in   (do_in),
        .den     (den_out),
        .daddr   (daddr_out),
        .sample  (rd_sample),
        .hit     (rd_hit),
        .expire  (rd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            acc         <= '0;
            cnt         <= '0;
            ch_q        <= '0;
            raw_q       <= '0;
            avg_q       <= '0;
            out_valid   <= 1'b0;
            out_ch      <= '0;
            out_raw     <= '0;
            out_avg     <= '0;
            out_mv      <= '0;
            overrun     <= 1'b0;
            drp_timeout <= 1'b0;
        end else begin
            overrun     <= eoc_in && (state != ST_IDLE);
            drp_timeout <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    ch_q  <= ch_off[CH_W-1:0];
                    state <= ST_REQ;
                end
                ST_REQ: state <= ST_WAIT;
                ST_WAIT: begin
                    if (rd_hit) begin
                        state <= ST_ACC;
                    end else if (rd_expire) begin
                        drp_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_ACC: begin
                    raw_q <= rd_sample;
                    if (cnt[ch_q] != CNT_LAST) begin
                        acc[ch_q] <= acc_sum;
                        cnt[ch_q] <= cnt[ch_q] + 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        avg_q     <= DATA_W'(acc_sum >> AVG_LOG2);
                        acc[ch_q] <= '0;
                        cnt[ch_q] <= '0;
                        state     <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    out_ch    <= ch_q;
                    out_raw   <= raw_q;
                    out_avg   <= avg_q;
                    out_mv    <= sat16(32'(prod >> SCALE_SHIFT));
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xadc_multichan_conditioner.sv
// Table-driven bench with a result scoreboard for xadc_multichan_conditioner
// (NUM_CH=2, FIRST_CH=0x1E, AVG_LOG2=2).
module tb_xadc_multichan_conditioner;
    localparam int CH_W = 1;

    logic        clk = 1'b0, reset = 1'b1, eoc_in = 1'b0, drdy_in = 1'b0, out_ready = 1'b1;
    logic [4:0]  channel_in = '0;
    logic [15:0] do_in = '0;
    logic        den_out, out_valid, overrun, drp_timeout;
    logic [6:0]  daddr_out;
    logic [CH_W-1:0] out_ch;
    logic [11:0] out_raw, out_avg;
    logic [15:0] out_mv;

    xadc_multichan_conditioner #(.NUM_CH(2), .FIRST_CH(5'h1E), .AVG_LOG2(2)) dut (
        .clk(clk), .reset(reset), .eoc_in(eoc_in), .channel_in(channel_in),
        .den_out(den_out), .daddr_out(daddr_out), .drdy_in(drdy_in), .do_in(do_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_raw(out_raw),
        .out_avg(out_avg), .out_mv(out_mv), .overrun(overrun), .drp_timeout(drp_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      ch;
        logic [15:0]     d;
        bit              last;
        logic [CH_W-1:0] e_ch;
        logic [11:0]     e_raw;
        logic [11:0]     e_avg;
        logic [15:0]     e_mv;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[12];
    int n_vec = 0, n_err = 0;
    int den_cnt = 0, ovr_cnt = 0, tmo_cnt = 0, hs_cnt = 0;

    function automatic vec_t mk(input logic [4:0] ch, input logic [15:0] d);
        vec_t v;
        v.ch = ch; v.d = d; v.last = 1'b0;
        v.e_ch = '0; v.e_raw = '0; v.e_avg = '0; v.e_mv = '0;
        return v;
    endfunction

    function automatic vec_t mkx(input logic [4:0] ch, input logic [15:0] d, input logic [CH_W-1:0] ec,
                                 input logic [11:0] er, input logic [11:0] ea, input logic [15:0] em);
        vec_t v;
        v = mk(ch, d);
        v.last = 1'b1; v.e_ch = ec; v.e_raw = er; v.e_avg = ea; v.e_mv = em;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Event counters and the scoreboard pop, sampled mid-cycle.
    always @(negedge clk) begin
        if (den_out === 1'b1) den_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
        if (drp_timeout === 1'b1) tmo_cnt++;
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            vec_t e;
            hs_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_result: ch=%0h avg=%0h mv=%0d, expected none", out_ch, out_avg, out_mv);
            end else begin
                e = exp_q.pop_front();
                chk("res_ch", 32'(out_ch), 32'(e.e_ch));
                chk("res_raw", 32'(out_raw), 32'(e.e_raw));
                chk("res_avg", 32'(out_avg), 32'(e.e_avg));
                chk("res_mv", 32'(out_mv), 32'(e.e_mv));
            end
        end
    end

    // One eoc -> den -> drdy transaction; a block-completing vector also checks d+3 latency.
    task automatic read_sample(input vec_t v);
        @(posedge clk); #1 eoc_in = 1'b1; channel_in = v.ch;
        @(posedge clk); #1 eoc_in = 1'b0;
        chk("den_out", 32'(den_out), 32'd1);
        chk("daddr", 32'(daddr_out), 32'({2'b00, v.ch}));
        @(posedge clk); #1 drdy_in = 1'b1; do_in = v.d;
        if (v.last) exp_q.push_back(v);
        @(posedge clk); #1 drdy_in = 1'b0; do_in = '0;
        if (v.last) chk("lat_d1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        if (v.last) chk("lat_d2", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        if (v.last) chk("lat_d3", 32'(out_valid), 32'd1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int den0, ov0, hs0, tmo0;

        tbl[0]  = mk (5'h1F, 16'hFFF0);
        tbl[1]  = mk (5'h1F, 16'hFFF0);
        tbl[2]  = mk (5'h1F, 16'hFFF0);
        tbl[3]  = mkx(5'h1F, 16'hFFF0, 1'b1, 12'hFFF, 12'hFFF, 16'd3299);
        tbl[4]  = mk (5'h1E, 16'h8000);
        tbl[5]  = mk (5'h1F, 16'h0000);
        tbl[6]  = mk (5'h1E, 16'h8000);
        tbl[7]  = mk (5'h1F, 16'h0000);
        tbl[8]  = mk (5'h1E, 16'h4000);
        tbl[9]  = mk (5'h1F, 16'h0000);
        tbl[10] = mkx(5'h1E, 16'h4000, 1'b0, 12'h400, 12'h600, 16'd1237);
        tbl[11] = mkx(5'h1F, 16'h0000, 1'b1, 12'h000, 12'h000, 16'd0);

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        chk("rst_den", 32'(den_out), 32'd0);
        chk("rst_daddr", 32'(daddr_out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_outs", 32'({out_ch, out_raw, out_avg}), 32'd0);
        chk("rst_mv", 32'(out_mv), 32'd0);
        chk("rst_flags", 32'({overrun, drp_timeout}), 32'd0);
        chk("rst_den_cnt", 32'(den_cnt), 32'd0);
        reset = 1'b0;

        // Full-scale block on ch1, then interleaved blocks on both channels
        for (int i = 0; i < 12; i++) read_sample(tbl[i]);
        chk("hs_after_tbl", 32'(hs_cnt), 32'd3);

        // Out-of-range channel is ignored silently
        den0 = den_cnt; ov0 = ovr_cnt;
        @(posedge clk); #1 eoc_in = 1'b1; channel_in = 5'h03;
        @(posedge clk); #1 eoc_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("oor_den", 32'(den_cnt), 32'(den0));
        chk("oor_overrun", 32'(ovr_cnt), 32'(ov0));

        // Stalled result: eoc drops with overrun, outputs hold, single accept
        out_ready = 1'b0;
        read_sample(mk(5'h1F, 16'h1230));
        read_sample(mk(5'h1F, 16'h1230));
        read_sample(mk(5'h1F, 16'h1230));
        read_sample(mkx(5'h1F, 16'h1230, 1'b1, 12'h123, 12'h123, 16'd234));
        den0 = den_cnt; ov0 = ovr_cnt; hs0 = hs_cnt;
        @(posedge clk); #1 eoc_in = 1'b1; channel_in = 5'h1E;
        @(posedge clk); #1 eoc_in = 1'b0;
        @(posedge clk); #1;
        chk("stall_overrun", 32'(ovr_cnt), 32'(ov0 + 1));
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_avg", 32'(out_avg), 32'h123);
        chk("stall_mv", 32'(out_mv), 32'd234);
        chk("stall_hs", 32'(hs_cnt), 32'(hs0));
        out_ready = 1'b1; eoc_in = 1'b1; channel_in = 5'h1E;
        @(posedge clk); #1 eoc_in = 1'b0;
        @(posedge clk); #1;
        chk("accept_once", 32'(hs_cnt), 32'(hs0 + 1));
        chk("hs_eoc_overrun", 32'(ovr_cnt), 32'(ov0 + 2));
        chk("accept_valid", 32'(out_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("dropped_no_den", 32'(den_cnt), 32'(den0));
        chk("accept_once_late", 32'(hs_cnt), 32'(hs0 + 1));

        // DRP timeout: no drdy_in after den_out
        tmo0 = tmo_cnt;
        @(posedge clk); #1 eoc_in = 1'b1; channel_in = 5'h1E;
        @(posedge clk); #1 eoc_in = 1'b0;
        chk("tmo_den", 32'(den_out), 32'd1);
        repeat (14) @(posedge clk);
        #1;
        chk("tmo_early", 32'(drp_timeout), 32'd0);
        @(posedge clk); #1;
        chk("tmo_pulse", 32'(drp_timeout), 32'd1);
        @(posedge clk); #1;
        chk("tmo_one_cycle", 32'(drp_timeout), 32'd0);
        chk("tmo_count", 32'(tmo_cnt), 32'(tmo0 + 1));

        // Reset mid-block: the next average must use only post-reset samples
        read_sample(mk(5'h1E, 16'hFFF0));
        read_sample(mk(5'h1E, 16'hFFF0));
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        read_sample(mk(5'h1E, 16'h1000));
        read_sample(mk(5'h1E, 16'h2000));
        read_sample(mk(5'h1E, 16'h3000));
        read_sample(mkx(5'h1E, 16'h4000, 1'b0, 12'h400, 12'h280, 16'd515));

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("total_results", 32'(hs_cnt), 32'd5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
